// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered result/flags, iterative MUL/DIV/MOD over WIDTH cycles.
// Define ALU_SEQ_SIGNED_MULDIV_EN to add IMUL (opcode 14) and IDIV (opcode 15).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zf,
    output logic             flag_sf,
    output logic             flag_cf,
    output logic             flag_of,
    output logic             div_err
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3,
        OP_MOD  = 4'd4,  OP_OR   = 4'd5,  OP_AND = 4'd6,  OP_XOR = 4'd7,
        OP_NOT  = 4'd8,  OP_NOR  = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11,
        OP_SAL  = 4'd12, OP_SAR  = 4'd13, OP_IMUL = 4'd14, OP_IDIV = 4'd15
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zf_q, zf_d, sf_q, sf_d, cf_q, cf_d, of_q, of_d;
    logic             div_err_q, div_err_d;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
`endif

    // Single-cycle datapath, evaluated straight from the request so it registers at accept.
    op_e              in_op;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   add_sum, sub_diff, shl_ext, shr_ext, sar_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_cf, sc_of, sc_def;

    assign in_op    = op_e'(operation);
    assign sh_amt   = operand_b[SHW-1:0];
    assign add_sum  = {1'b0, operand_a} + {1'b0, operand_b};
    assign sub_diff = {1'b0, operand_a} - {1'b0, operand_b};
    assign shl_ext  = {1'b0, operand_a} << sh_amt;
    assign shr_ext  = {operand_a, 1'b0} >> sh_amt;
    assign sar_ext  = $signed({operand_a, 1'b0}) >>> sh_amt;

    always_comb begin
        sc_res = '0;
        sc_cf  = 1'b0;
        sc_of  = 1'b0;
        sc_def = 1'b1;
        case (in_op)
            OP_ADD: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_cf  = add_sum[WIDTH];
                sc_of  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_diff[WIDTH-1:0];
                sc_cf  = sub_diff[WIDTH];
                sc_of  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                         (sub_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_OR:  sc_res = operand_a | operand_b;
            OP_AND: sc_res = operand_a & operand_b;
            OP_XOR: sc_res = operand_a ^ operand_b;
            OP_NOT: sc_res = ~operand_a;
            OP_NOR: sc_res = ~(operand_a | operand_b);
            OP_SHL, OP_SAL: begin
                sc_res = shl_ext[WIDTH-1:0];
                sc_cf  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                sc_res = shr_ext[WIDTH:1];
                sc_cf  = shr_ext[0];
            end
            OP_SAR: begin
                sc_res = sar_ext[WIDTH:1];
                sc_cf  = sar_ext[0];
            end
            default: sc_def = 1'b0;
        endcase
    end

    // Request classification; signed ops feed magnitudes into the unsigned engine.
    logic             is_iter, is_derr;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_iter = in_op inside {OP_MUL, OP_DIV, OP_MOD};
        is_derr = (in_op inside {OP_DIV, OP_MOD}) && (operand_b == '0);
        mag_a   = operand_a;
        mag_b   = operand_b;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
        if (in_op inside {OP_IMUL, OP_IDIV}) begin
            is_iter = 1'b1;
            mag_a   = operand_a[WIDTH-1] ? -operand_a : operand_a;
            mag_b   = operand_b[WIDTH-1] ? -operand_b : operand_b;
        end
        if ((in_op == OP_IDIV) &&
            ((operand_b == '0) || ((operand_a == MIN_NEG) && (operand_b == '1))))
            is_derr = 1'b1;
`endif
    end

    // One step of shift-add multiply ({hi,lo} = product) or restoring divide (lo = quotient, hi = remainder).
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, div_sub;
    logic             div_ok, is_mul;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_hi_n  = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ok    = div_shift >= {1'b0, dvs_q};
    assign div_sub   = div_shift[WIDTH-1:0] - dvs_q;
    assign div_hi_n  = div_ok ? div_sub : div_shift[WIDTH-1:0];
    assign div_lo_n  = {lo_q[WIDTH-2:0], div_ok};
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
    assign is_mul    = (op_q == OP_MUL) || (op_q == OP_IMUL);
`else
    assign is_mul    = (op_q == OP_MUL);
`endif

    logic [WIDTH-1:0] fin_res, fin_hi;
    logic             fin_cf, fin_of;

    always_comb begin
        fin_res = '0;
        fin_hi  = '0;
        fin_cf  = 1'b0;
        fin_of  = 1'b0;
        case (op_q)
            OP_MUL: begin
                fin_res = mul_lo_n;
                fin_hi  = mul_hi_n;
                fin_cf  = (mul_hi_n != '0);
            end
            OP_DIV: begin
                fin_res = div_lo_n;
                fin_hi  = div_hi_n;
            end
            OP_MOD: begin
                fin_res = div_hi_n;
                fin_hi  = div_lo_n;
            end
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
            OP_IMUL: begin
                {fin_hi, fin_res} = neg_quo_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
                fin_cf = (fin_hi != {WIDTH{fin_res[WIDTH-1]}});
                fin_of = fin_cf;
            end
            OP_IDIV: begin
                fin_res = neg_quo_q ? -div_lo_n : div_lo_n;
                fin_hi  = neg_rem_q ? -div_hi_n : div_hi_n;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        cf_d        = cf_q;
        of_d        = of_q;
        div_err_d   = div_err_q;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: if (in_valid) begin
                op_d = in_op;
                if (is_derr) begin
                    result_d    = '1;
                    result_hi_d = operand_a;
                    zf_d        = 1'b0;
                    sf_d        = 1'b1;
                    cf_d        = 1'b0;
                    of_d        = 1'b0;
                    div_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (is_iter) begin
                    hi_d    = '0;
                    lo_d    = mag_a;
                    dvs_d   = mag_b;
                    cnt_d   = '0;
                    state_d = S_BUSY;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
                    neg_quo_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    neg_rem_d = operand_a[WIDTH-1];
`endif
                end else begin
                    result_d    = sc_res;
                    result_hi_d = '0;
                    zf_d        = sc_def && (sc_res == '0);
                    sf_d        = sc_res[WIDTH-1];
                    cf_d        = sc_cf;
                    of_d        = sc_of;
                    div_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_BUSY: begin
                hi_d  = is_mul ? mul_hi_n : div_hi_n;
                lo_d  = is_mul ? mul_lo_n : div_lo_n;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d    = fin_res;
                    result_hi_d = fin_hi;
                    zf_d        = (fin_res == '0);
                    sf_d        = fin_res[WIDTH-1];
                    cf_d        = fin_cf;
                    of_d        = fin_of;
                    div_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            hi_q        <= '0;
            lo_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
            cf_q        <= 1'b0;
            of_q        <= 1'b0;
            div_err_q   <= 1'b0;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            cf_q        <= cf_d;
            of_q        <= of_d;
            div_err_q   <= div_err_d;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_zf   = zf_q;
    assign flag_sf   = sf_q;
    assign flag_cf   = cf_q;
    assign flag_of   = of_q;
    assign div_err   = div_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): expected results queued at drive, compared at out_valid.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [3:0]   operation;
    logic [W-1:0] operand_a, operand_b, result, result_hi;
    logic         flag_zf, flag_sf, flag_cf, flag_of, div_err;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .flag_zf(flag_zf), .flag_sf(flag_sf), .flag_cf(flag_cf), .flag_of(flag_of),
        .div_err(div_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [4:0]  flg;   // {zf, sf, cf, of, div_err}
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic fits32(input longint v);
        logic [63:0] u;
        u = v;
        return v == longint'(int'(u[31:0]));
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input string tag);
        exp_t        e;
        longint      sa, sb, sr, sq;
        logic [63:0] p, u;
        int          amt;
        logic        cf, of, err, def;
        e.tag = tag; e.res = '0; e.hi = '0; e.lat = 1;
        cf = 1'b0; of = 1'b0; err = 1'b0; def = 1'b1;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(b[4:0]);
        case (op)
            4'd0: begin
                p = 64'(a) + 64'(b); e.res = p[31:0]; cf = p[32];
                of = !fits32(sa + sb);
            end
            4'd1: begin
                e.res = a - b; cf = (a < b);
                of = !fits32(sa - sb);
            end
            4'd2: begin
                p = 64'(a) * 64'(b); e.res = p[31:0]; e.hi = p[63:32];
                cf = (p[63:32] != 0); e.lat = 33;
            end
            4'd3: if (b == 0) err = 1'b1; else begin e.res = a / b; e.hi = a % b; e.lat = 33; end
            4'd4: if (b == 0) err = 1'b1; else begin e.res = a % b; e.hi = a / b; e.lat = 33; end
            4'd5: e.res = a | b;
            4'd6: e.res = a & b;
            4'd7: e.res = a ^ b;
            4'd8: e.res = ~a;
            4'd9: e.res = ~(a | b);
            4'd10, 4'd12: begin
                p = 64'(a) << amt; e.res = p[31:0]; cf = p[32];
            end
            4'd11: begin
                e.res = a >> amt;
                if (amt != 0) cf = a[amt-1];
            end
            4'd13: begin
                e.res = 32'($signed(a) >>> amt);
                if (amt != 0) cf = a[amt-1];
            end
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
            4'd14: begin
                sr = sa * sb; u = sr;
                e.res = u[31:0]; e.hi = u[63:32];
                cf = !fits32(sr); of = cf; e.lat = 33;
            end
            4'd15: begin
                if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) err = 1'b1;
                else begin
                    sq = sa / sb; sr = sa % sb;
                    u = sq; e.res = u[31:0];
                    u = sr; e.hi = u[31:0];
                    e.lat = 33;
                end
            end
`endif
            default: def = 1'b0;
        endcase
        if (err) begin
            e.res = 32'hFFFF_FFFF; e.hi = a; e.lat = 1;
            e.flg = 5'b01001;
        end else begin
            e.flg = {def && (e.res == 0), e.res[31], cf, of, 1'b0};
        end
        return e;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; operation = op; operand_a = a; operand_b = b;
        sb_q.push_back(model(op, a, b, tag));
        @(posedge clk); #1;
        lat = 1;
        // Junk request held high while the block is occupied; it must be ignored.
        operation = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
        while (!out_valid && lat < 100) begin
            check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        if (lat >= 100) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
        e = sb_q.pop_front();
        check({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({e.tag, "_result"}, 64'(result), 64'(e.res));
        check({e.tag, "_result_hi"}, 64'(result_hi), 64'(e.hi));
        check({e.tag, "_flags"}, 64'({flag_zf, flag_sf, flag_cf, flag_of, div_err}), 64'(e.flg));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({e.tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({e.tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            check({e.tag, "_hold_result"}, 64'(result), 64'(e.res));
            check({e.tag, "_hold_flags"}, 64'({flag_zf, flag_sf, flag_cf, flag_of, div_err}), 64'(e.flg));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({e.tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({e.tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stale;
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        operation = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);

        run_op(4'd0, 32'hFFFF_FFFF, 32'h1, "add_carry", 0);
        run_op(4'd1, 32'h8000_0000, 32'h1, "sub_ovf", 0);

        // Reset ten cycles into a multiply: everything clears and no result ever surfaces.
        @(negedge clk);
        in_valid = 1'b1; operation = 4'd2; operand_a = 32'h1_0000; operand_b = 32'h1_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_mul_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); rst = 1'b1;
        #1;
        check("async_clr_result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mul_out_valid", 64'(out_valid), 64'd0);
        check("rst_mul_in_ready", 64'(in_ready), 64'd1);
        check("rst_mul_result", 64'(result), 64'd0);
        check("rst_mul_result_hi", 64'(result_hi), 64'd0);
        check("rst_mul_flags", 64'({flag_zf, flag_sf, flag_cf, flag_of, div_err}), 64'd0);
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("rst_mul_no_stale", 64'(stale), 64'd0);

        run_op(4'd2,  32'h0001_0000, 32'h0001_0000, "mul_1_0000", 0);
        run_op(4'd3,  32'd100,       32'd7,         "div_100_7", 0);
        run_op(4'd4,  32'd100,       32'd7,         "mod_100_7", 0);
        run_op(4'd3,  32'd5,         32'd0,         "div_by_zero", 0);
        run_op(4'd4,  32'd9,         32'd0,         "mod_by_zero", 0);
        run_op(4'd13, 32'h8000_0000, 32'h21,        "sar_amt1", 0);
        run_op(4'd11, 32'h8000_0000, 32'h21,        "shr_amt1", 0);
        run_op(4'd10, 32'h8000_0001, 32'h1,         "shl_amt1", 0);
        run_op(4'd12, 32'h8000_0001, 32'h20,        "sal_amt0", 0);
        run_op(4'd13, 32'h8000_0001, 32'h1F,        "sar_amt31", 0);
        run_op(4'd0,  32'h7FFF_FFFF, 32'h1,         "add_ovf", 0);
        run_op(4'd1,  32'd3,         32'd5,         "sub_borrow", 0);
        run_op(4'd5,  32'hF0F0_0000, 32'h0000_0F0F, "or", 0);
        run_op(4'd6,  32'hF0F0_0000, 32'h0F0F_0000, "and_zero", 0);
        run_op(4'd7,  32'hFFFF_0000, 32'hFF00_FF00, "xor", 0);
        run_op(4'd8,  32'h1234_5678, 32'h0,         "not", 0);
        run_op(4'd9,  32'h1234_5678, 32'h0F00_0000, "nor", 0);
        run_op(4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max", 0);
        run_op(4'd3,  32'hFFFF_FFFF, 32'd3,         "div_max_3", 0);
        run_op(4'd0,  32'h1234_5678, 32'h1111_1111, "bp_add", 5);
        run_op(4'd15, 32'hFFFF_FFF9, 32'd2,         "op15_neg7_2", 0);
        run_op(4'd15, 32'h8000_0000, 32'hFFFF_FFFF, "op15_min_m1", 0);
        run_op(4'd15, 32'd7,         32'd0,         "op15_by_zero", 0);
        run_op(4'd14, 32'hFFFF_FFFD, 32'd5,         "op14_neg3_5", 0);
        run_op(4'd14, 32'h8000_0000, 32'h8000_0000, "op14_min_min", 0);

        for (int i = 0; i < 24; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op(r_op, r_a, r_b, $sformatf("rnd%0d_op%0d", i, r_op), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
